// File: rtl/dot_channel_seq_pkg.sv
// ============================================================================
// Module      : dot_channel_seq_pkg
// Description : Shared widths and state encoding for the dot-channel
//               sequencer.
// Revision    : 1.1
// ============================================================================
`default_nettype none
`ifndef DATA_LEN_BITS
`define DATA_LEN_BITS 16
`endif

package dot_channel_seq_pkg;
    localparam int DATA_LEN = `DATA_LEN_BITS;
    localparam int CS_W     = 4;
    localparam int PHASE_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } seq_state_t;
endpackage
`default_nettype wire

// File: rtl/dot_seq_acc.sv
// Phase accumulator: loads the first partial sum, then adds the rest modulo 2^DATA_LEN.
`default_nettype none
module dot_seq_acc
   import dot_channel_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                first,
   input  logic                add,
   input  logic [DATA_LEN-1:0] din,
   output logic [DATA_LEN-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (first) begin
         q <= din;
      end else if (add) begin
         q <= q + din;
      end
   end
endmodule
`default_nettype wire

// File: rtl/dot_channel_seq.sv
// Dot-channel sequencer: walks phases and channel chunks, accumulates each phase, hands it off.
// Optional DOT_SEQ_TIMEOUT_EN adds a dot_valid watchdog and the sticky err port.
`default_nettype none
module dot_channel_seq
   import dot_channel_seq_pkg::*;
#(
   parameter int NUM_CS    = 9,
   parameter int NUM_PHASE = 7
`ifdef DOT_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 64
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                ws_load,
   output logic                dc_load,
   output logic [CS_W-1:0]     cs,
   output logic [PHASE_W-1:0]  phase,
   input  logic                dot_valid,
   input  logic [DATA_LEN-1:0] dot_q,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_data
`ifdef DOT_SEQ_TIMEOUT_EN
   ,
   output logic                err
`endif
);
   localparam logic [CS_W-1:0]    CS_LAST    = CS_W'(NUM_CS - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASE - 1);

   seq_state_t         state, state_nx;
   logic [CS_W-1:0]    cs_nx;
   logic [PHASE_W-1:0] phase_nx;
   logic               acc_first, acc_add;
   logic               timed_out;

`ifdef DOT_SEQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_cnt;

   // The counter is zero on the first cycle of every LOAD stretch.
   assign timed_out = (state == LOAD) && !dot_valid && (wait_cnt == WAIT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         wait_cnt <= (state == LOAD) ? wait_cnt + 1'b1 : '0;
         if (timed_out) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cs    <= '0;
         phase <= '0;
      end else begin
         state <= state_nx;
         cs    <= cs_nx;
         phase <= phase_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cs_nx     = cs;
      phase_nx  = phase;
      acc_first = 1'b0;
      acc_add   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = LOAD;
               cs_nx    = '0;
               phase_nx = '0;
            end
         end
         LOAD: begin
            if (dot_valid) begin
               acc_first = (cs == '0);
               acc_add   = (cs != '0);
               state_nx  = DRAIN;
            end else if (timed_out) begin
               // Abandon the partial phase; no result is offered downstream.
               state_nx = FIN;
               cs_nx    = '0;
               phase_nx = '0;
            end
         end
         DRAIN: begin
            if (cs < CS_LAST) begin
               cs_nx    = cs + 1'b1;
               state_nx = LOAD;
            end else begin
               state_nx = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               cs_nx = '0;
               if (phase < PHASE_LAST) begin
                  phase_nx = phase + 1'b1;
                  state_nx = LOAD;
               end else begin
                  phase_nx = '0;
                  state_nx = FIN;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign ws_load   = (state == LOAD);
   assign dc_load   = (state == LOAD);
   assign out_valid = (state == OUT);

   dot_seq_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .first (acc_first),
      .add   (acc_add),
      .din   (dot_q),
      .q     (out_data)
   );
endmodule
`default_nettype wire

// File: tb/tb_dot_channel_seq.sv
// Randomized bench for dot_channel_seq with a queue-based phase-sum model.
`default_nettype none
module tb_dot_channel_seq;
   import dot_channel_seq_pkg::*;

   localparam int NCS = 3;
   localparam int NPH = 2;
   localparam int TO  = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                dot_valid = 1'b0;
   logic                out_ready = 1'b0;
   logic [DATA_LEN-1:0] dot_q = '0;
   logic                busy, done, ws_load, dc_load, out_valid;
   logic [CS_W-1:0]     cs;
   logic [PHASE_W-1:0]  phase;
   logic [DATA_LEN-1:0] out_data;
`ifdef DOT_SEQ_TIMEOUT_EN
   logic                err;
`endif

   int checks = 0;
   int errors = 0;

   dot_channel_seq #(
      .NUM_CS    (NCS),
      .NUM_PHASE (NPH)
`ifdef DOT_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT   (TO)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .ws_load   (ws_load),
      .dc_load   (dc_load),
      .cs        (cs),
      .phase     (phase),
      .dot_valid (dot_valid),
      .dot_q     (dot_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DOT_SEQ_TIMEOUT_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   // Model: every value handed out while loads are high is one chunk; NCS chunks make a phase sum.
   logic [DATA_LEN-1:0] exp_q[$];
   logic [DATA_LEN-1:0] got_q[$];
   logic [DATA_LEN-1:0] dir_vals[$];
   logic [DATA_LEN-1:0] sum;
   int  chunk, res_cnt, ov_cd, gap, lcnt, lat, done_cnt, hold_cnt, load_cycles, ready_mode;
   bit  exp_busy, exp_ov, pend_done, exp_err, start_req, respond_en, garbage_en, inj_start;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      sum = '0;
      chunk = 0; res_cnt = 0; ov_cd = 0; gap = 0; lcnt = 0; load_cycles = 0;
      exp_busy = 0; exp_ov = 0; pend_done = 0;
   endtask

   task automatic step();
      logic [DATA_LEN-1:0] v;
      @(negedge clk);
      chk("busy", busy, exp_busy);
      chk("done", done, pend_done);
      if (done) done_cnt++;
      if (pend_done) begin
         pend_done = 0;
         exp_busy  = 0;
      end
`ifdef DOT_SEQ_TIMEOUT_EN
      chk("err", err, exp_err);
`endif
      chk("dc_load", dc_load, ws_load);
      if (ov_cd > 0) begin
         ov_cd--;
         if (ov_cd == 0) exp_ov = 1;
      end
      chk("out_valid", out_valid, exp_ov);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_data: got %0h with no result due", out_data);
         end else begin
            chk("out_data", out_data, exp_q[0]);
         end
         chk("load_during_out", ws_load, 0);
      end
      if (ws_load || out_valid) chk("phase", phase, res_cnt);
      if (ws_load) begin
         chk("cs", cs, chunk);
         if (gap > 0) chk("load_gap", gap, 1);
         gap = 0;
         load_cycles++;
      end else if (busy && !out_valid && !done) begin
         gap++;
      end else begin
         gap = 0;
      end
`ifdef DOT_SEQ_TIMEOUT_EN
      if (ws_load && !respond_en && load_cycles == TO) begin
         pend_done = 1;
         exp_err   = 1;
      end
`endif

      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom % 2);
         default: begin
            if (out_valid && res_cnt == 0) begin
               out_ready = (hold_cnt >= 5);
               hold_cnt++;
            end else begin
               out_ready = 1'b1;
            end
         end
      endcase
      if (out_valid && out_ready && exp_q.size() > 0) begin
         got_q.push_back(out_data);
         void'(exp_q.pop_front());
         exp_ov = 0;
         res_cnt++;
         if (res_cnt == NPH) begin
            res_cnt   = 0;
            pend_done = 1;
         end
      end

      if (ws_load && respond_en) begin
         if (lcnt >= lat) begin
            if (dir_vals.size() > 0) v = dir_vals.pop_front();
            else                     v = DATA_LEN'($urandom);
            dot_valid = 1'b1;
            dot_q     = v;
            sum       = sum + v;
            chunk++;
            lcnt = 0;
            lat  = $urandom_range(0, 2);
            if (chunk == NCS) begin
               exp_q.push_back(sum);
               sum   = '0;
               chunk = 0;
               ov_cd = 2;
            end
         end else begin
            dot_valid = 1'b0;
            dot_q     = DATA_LEN'($urandom);
            lcnt++;
         end
      end else begin
         dot_valid = garbage_en ? 1'($urandom % 2) : 1'b0;
         dot_q     = DATA_LEN'($urandom);
         if (!ws_load) lcnt = 0;
      end

      start = start_req || (inj_start && exp_busy && ($urandom % 5 == 0));
      if (start && !exp_busy) exp_busy = 1;
   endtask

   task automatic start_run();
      load_cycles = 0;
      start_req = 1;
      step();
      start_req = 0;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s: got no done pulse, required one within %0d cycles", tag, budget);
      end
   endtask

   initial begin
      int n, d0;
      logic [DATA_LEN-1:0] all_ones;
      all_ones = '1;
      reset_model();
      exp_err = 0; start_req = 0; respond_en = 1; garbage_en = 0; inj_start = 0;
      ready_mode = 0; lat = 0; done_cnt = 0; hold_cnt = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ws_load", ws_load, 0);
      chk("rst_cs", cs, 0);
      chk("rst_phase", phase, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      rst_n = 1'b1;

      // Directed sums 1+2+3 and 4+5+6.
      for (int i = 1; i <= 6; i++) dir_vals.push_back(DATA_LEN'(i));
      got_q.delete();
      start_run();
      run_until_done(200, "directed_run");
      chk("directed_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("directed_sum0", got_q[0], 6);
         chk("directed_sum1", got_q[1], 15);
      end

      // Downstream stalls the phase-0 result for five cycles.
      ready_mode = 2; hold_cnt = 0;
      start_run();
      run_until_done(200, "hold_run");
      chk("hold_valid_cycles", hold_cnt, 6);

      // Wrap-around of the modulo adder.
      ready_mode = 0;
      dir_vals.push_back(all_ones);
      dir_vals.push_back(all_ones);
      dir_vals.push_back('0);
      got_q.delete();
      start_run();
      run_until_done(200, "wrap_run");
      if (got_q.size() >= 1) chk("wrap_sum", got_q[0], all_ones - 1'b1);
      else chk("wrap_count", got_q.size(), 2);

      // Random runs with stray dot_valid, start while busy and random ready.
      garbage_en = 1; inj_start = 1; ready_mode = 1;
      for (int r = 0; r < 6; r++) begin
         d0 = done_cnt;
         start_run();
         run_until_done(400, "random_run");
         repeat (5) step();
         chk("done_pulses", done_cnt, d0 + 1);
      end

      // Asynchronous reset while loading chunk 1.
      garbage_en = 0; inj_start = 0; ready_mode = 0;
      start_run();
      n = 0;
      while (!(ws_load && cs == 1) && n < 100) begin
         step();
         n++;
      end
      chk("reached_cs1", ws_load && cs == 1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ws_load", ws_load, 0);
      chk("arst_cs", cs, 0);
      chk("arst_phase", phase, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_done", done, 0);
      reset_model();
      start = 1'b0; dot_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      got_q.delete();
      start_run();
      run_until_done(200, "post_reset_run");
      chk("post_reset_count", got_q.size(), NPH);

      // Datapath never answers.
      respond_en = 0;
      start_run();
`ifdef DOT_SEQ_TIMEOUT_EN
      run_until_done(100, "timeout_run");
      chk("timeout_load_cycles", load_cycles, TO);
      chk("timeout_err", err, 1);
      repeat (3) step();
`else
      repeat (40) step();
      chk("stall_busy", busy, 1);
      chk("stall_ws_load", ws_load, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dot_channel_seq.md
Name: dot_channel_seq

Overview:
- Sequencer for one dot-channel datapath. The datapath is a weight store plus a 36-wide inner product, producing one `data_len` partial sum per (cs, phase).
- Walks every phase and, inside each phase, every channel chunk cs.
- Drives ws_load/dc_load, waits for the datapath valid, then accumulates the NUM_CS partial sums of each phase into one result.
- Emits the result with a valid/ready handshake.
- Sits between the layer controller (start/done) and one dot channel instance.

Parameters:
- NUM_CS, 9, channel chunks per phase; legal range 1..16.
- NUM_PHASE, 7, phases per run; legal range 1..8.
- TIMEOUT, 64, max cycles waiting for dot_valid; used only with DOT_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request; ignored while busy.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last phase result is accepted.
- ws_load  out  1  to datapath weight store.
- dc_load  out  1  to datapath inner product.
- cs  out  4  chunk select to the datapath.
- phase  out  3  phase select to the datapath.
- dot_valid  in  1  datapath result valid.
- dot_q  in  `data_len  datapath partial sum.
- out_valid  out  1  phase result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  `data_len  accumulated phase result.
- err  out  1  sticky timeout flag; exists only with DOT_SEQ_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, cs = 0, phase = 0, accumulator 0, state IDLE.
- Reset asserted mid-run aborts immediately, with no done pulse.
- States: IDLE, LOAD, DRAIN, OUT, FIN.
- IDLE:
  - start=1 → LOAD, with cs=0, phase=0, busy=1 from the next cycle.
  - start in any other state is ignored.
- LOAD:
  - ws_load=dc_load=1, holding the current cs/phase stable.
  - On dot_valid=1:
    - if cs==0, acc<=dot_q; otherwise acc<=acc+dot_q.
    - Addition is modulo 2^`data_len`, wrap, no saturation.
    - Then → DRAIN.
- DRAIN:
  - Lasts exactly one cycle, with ws_load=dc_load=0 so the datapath clears its internal count.
  - If cs<NUM_CS-1: cs<=cs+1 → LOAD.
  - Otherwise → OUT with out_valid=1 and out_data=acc.
- OUT:
  - out_valid and out_data held stable until out_ready=1 (transfer cycle).
  - On transfer: out_valid<=0, cs<=0.
  - If phase<NUM_PHASE-1: phase<=phase+1 → LOAD; otherwise → FIN.
  - out_ready ignored when out_valid=0.
- FIN: done=1 for one cycle, busy<=0 → IDLE. cs/phase stay 0.
- dot_valid outside LOAD is ignored.
- NUM_CS=1: every phase result equals its single dot_q.
- Latency per phase with datapath valid after L load cycles: NUM_CS*(L+1) cycles plus 1 OUT cycle minimum.

Optional Feature:
- DOT_SEQ_TIMEOUT_EN defined:
  - A wait counter clears on entering LOAD and increments every LOAD cycle.
  - Reaching TIMEOUT without dot_valid sets err=1 (sticky until reset), drops the loads and goes to FIN, which pulses done.
  - Any partial phase result is discarded, with no out_valid.
  - The err port exists.
- Undefined: no counter and no err port. LOAD waits indefinitely.

Decomposition:
- Shared package/header: state encoding constants; `data_len` from the existing num_data.v include; CS_W=4 and PHASE_W=3 widths.
- One natural sub-module: dot_seq_acc, the accumulator register with first/add controls and a modulo adder.

Test Plan:
- NUM_CS=3, NUM_PHASE=2, bench returns dot_q=1,2,3 then 4,5,6, out_ready=1 → out_data 6 then 15, then a done pulse. cs sequence 0,1,2 per phase. Loads low for exactly one cycle between chunks.
- out_ready held 0 for 5 cycles on phase 0 → out_valid/out_data stable for 5 cycles, phase stays 0, no LOAD until accepted.
- dot_q=2^`data_len`-1 twice with NUM_CS=2 → out_data=2^`data_len`-2 (wrap).
- start pulsed while busy, plus dot_valid injected in IDLE/OUT → no effect on the count, the results, or the number of done pulses.
- rst_n dropped during LOAD of cs=1 → outputs 0 asynchronously. A fresh start completes a normal run.
- DOT_SEQ_TIMEOUT_EN, TIMEOUT=8, dot_valid never returned → err=1 after 8 LOAD cycles, done pulses, no out_valid. Without the macro, the sequencer stays in LOAD.
